// File: rtl/cnt_arb_pkg.sv
// rtl/cnt_arb_pkg.sv - shared constants and state encoding for counter_arbiter
package cnt_arb_pkg;

    localparam int CNT_ARB_N_REQ = 4;
    localparam int CNT_ARB_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational priority pick starting at a rotating base index
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    base,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    // Walk offsets from the top down so the smallest offset from base wins.
    always_comb begin
        int sel;
        int p;
        sel = -1;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            p = (int'(base) + k) % N_REQ;
            if (req[p]) begin
                sel = p;
            end
        end
        valid  = (sel >= 0);
        onehot = '0;
        idx    = '0;
        if (sel >= 0) begin
            onehot = N_REQ'(1) << sel;
            idx    = IW'(sel);
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - shared delay counter granted to one requester at a time (CNT_ARB_RR_EN selects round-robin)
module counter_arbiter
    import cnt_arb_pkg::*;
#(
    parameter int N_REQ = CNT_ARB_N_REQ,
    parameter int WIDTH = CNT_ARB_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] len,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [WIDTH-1:0]       count
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef CNT_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    state_t           state;
    logic [WIDTH-1:0] len_q;
    logic [IW-1:0]    last;
    logic [IW-1:0]    w;
    logic [IW-1:0]    base;
    logic [N_REQ-1:0] pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;

    // Search starts one past the previous winner; fixed priority always starts at 0.
    always_comb begin
        base = '0;
        if (RR_EN) begin
            base = (last == IW'(N_REQ - 1)) ? '0 : last + IW'(1);
        end
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req    (req),
        .base   (base),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign busy = (state != ST_IDLE);

    // Arbitration, run/terminal/abort handling and the one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            gnt   <= '0;
            done  <= '0;
            count <= '0;
            len_q <= '0;
            last  <= IW'(N_REQ - 1);
            w     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done  <= '0;
                    count <= '0;
                    if (pick_valid) begin
                        state <= ST_RUN;
                        gnt   <= pick_onehot;
                        w     <= pick_idx;
                        len_q <= len[pick_idx*WIDTH +: WIDTH];
                    end
                end
                ST_RUN: begin
                    if (!req[w]) begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                        count <= '0;
                        last  <= w;
                    end else if (count == len_q) begin
                        state <= ST_DONE;
                        done  <= gnt;
                        gnt   <= '0;
                        count <= '0;
                        last  <= w;
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= '0;
                    count <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    done  <= '0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - directed self-checking bench for counter_arbiter
module tb_counter_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] len = '0;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [7:0]  count;

    int total = 0;
    int bad   = 0;

    counter_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; len = '0;
        tick(); tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL reset_done got=%b exp=0000", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        len[7:0] = 8'd3;
        req = 4'b0001;
        for (int k = 0; k <= 3; k++) begin
            tick();
            total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt k=%0d got=%b exp=0001", k, gnt); end
            total++; if (count !== 8'(k)) begin bad++; $display("FAIL single_count got=%0d exp=%0d", count, k); end
        end
        tick();
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL single_done got=%b exp=0001", done); end
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_gnt_off got=%b exp=0000", gnt); end
        total++; if (count !== 8'd0) begin bad++; $display("FAIL single_count_after got=%0d exp=0", count); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_done got=%b exp=1", busy); end
        req = 4'b0000;
        tick();
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL single_done_clear got=%b exp=0000", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", busy); end
    endtask

    task automatic test_rotate();
        logic [3:0] exp_g [4];
`ifdef CNT_ARB_RR_EN
        exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
`else
        exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
`endif
        len = '0;
        req = 4'b1110;
        for (int g = 0; g < 4; g++) begin
            tick();
            total++; if (gnt !== exp_g[g]) begin bad++; $display("FAIL rotate_gnt g=%0d got=%b exp=%b", g, gnt, exp_g[g]); end
            tick();
            total++; if (done !== exp_g[g]) begin bad++; $display("FAIL rotate_done g=%0d got=%b exp=%b", g, done, exp_g[g]); end
            tick();
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rotate_idle g=%0d got=%b exp=0", g, busy); end
        end
        req = 4'b0000;
        tick(); tick(); tick();
    endtask

    task automatic test_long();
        int run = 0;
        int npulse = 0;
        int maxc = 0;
        int wrapbad = 0;
        logic [3:0] dval = '0;
        len[23:16] = 8'd255;
        req = 4'b0100;
        for (int i = 0; i < 300 && npulse == 0; i++) begin
            tick();
            if (gnt === 4'b0100) begin
                if (int'(count) != run) wrapbad++;
                if (int'(count) > maxc) maxc = int'(count);
                run++;
            end
            if (done !== 4'b0000) begin
                npulse++;
                dval = done;
            end
        end
        req = 4'b0000;
        total++; if (run != 256) begin bad++; $display("FAIL long_run_cycles got=%0d exp=256", run); end
        total++; if (maxc != 255) begin bad++; $display("FAIL long_max_count got=%0d exp=255", maxc); end
        total++; if (wrapbad != 0) begin bad++; $display("FAIL long_count_seq got=%0d exp=0", wrapbad); end
        total++; if (dval !== 4'b0100) begin bad++; $display("FAIL long_done got=%b exp=0100", dval); end
        tick();
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL long_single_pulse got=%b exp=0000", done); end
        tick();
    endtask

    task automatic test_abort();
        len[7:0] = 8'd5;
        req = 4'b0001;
        tick(); tick(); tick();
        total++; if (count !== 8'd2) begin bad++; $display("FAIL abort_pre_count got=%0d exp=2", count); end
        req = 4'b0000;
        tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL abort_gnt got=%b exp=0000", gnt); end
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL abort_done got=%b exp=0000", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        total++; if (count !== 8'd0) begin bad++; $display("FAIL abort_count got=%0d exp=0", count); end
        tick();
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL abort_no_pulse got=%b exp=0000", done); end
    endtask

    task automatic test_reset_mid();
        len[15:8] = 8'd20;
        req = 4'b0010;
        for (int k = 0; k < 8; k++) tick();
        total++; if (count !== 8'd7) begin bad++; $display("FAIL rstmid_pre_count got=%0d exp=7", count); end
        rst = 1'b0;
        tick();
        total++; if (count !== 8'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", count); end
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rstmid_gnt got=%b exp=0000", gnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL rstmid_done got=%b exp=0000", done); end
        rst = 1'b1;
        req = 4'b0000;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_pend;
`ifdef CNT_ARB_RR_EN
        exp_pend = 4'b0010;
`else
        exp_pend = 4'b0001;
`endif
        len = '0;
        req = 4'b0001;
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL b2b_gnt1 got=%b exp=0001", gnt); end
        tick();
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL b2b_done1 got=%b exp=0001", done); end
        tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL b2b_gap got=%b exp=0000", gnt); end
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL b2b_regrant got=%b exp=0001", gnt); end
        req = 4'b0011;
        tick();
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL b2b_done2 got=%b exp=0001", done); end
        tick();
        tick();
        total++; if (gnt !== exp_pend) begin bad++; $display("FAIL b2b_pending got=%b exp=%b", gnt, exp_pend); end
        req = 4'b0000;
        tick(); tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_final_idle got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotate();
        test_long();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
